sprite_anim_renderer: RTL and testbench

//  Parametrised successor to the full-screen sprite ROM/palette examples. Places one

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_anim_ctrl.sv | 72 +++++++
 rtl/sprite_anim_renderer.sv | 110 +++++++++++
 tb/tb_sprite_anim_renderer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared raster constants, coordinate type and animation state encoding
// for the sprite renderer.
package sprite_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } anim_state_e;

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: divides frame ticks down to animation steps and
// walks the frame counter, either looping or stopping on the last frame.
//
//   state | meaning
//   RUN   | anim_run high, ticks advance the divider and frame
//   HOLD  | anim_run low, divider and frame frozen
//   DONE  | one-shot finished on the last frame; only anim_start leaves
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int FRAMES    = 4,
  parameter int ANIM_DIV  = 8,
  parameter int ANIM_LOOP = 1
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          anim_run,
  input  logic                          anim_start,
  output logic [width_of(FRAMES)-1:0]   frame_num,
  output logic                          anim_done
);

  localparam int                DW       = width_of(ANIM_DIV);
  localparam int                FW       = width_of(FRAMES);
  localparam logic [DW-1:0]     DIV_LAST = DW'(ANIM_DIV - 1);
  localparam logic [FW-1:0]     FRM_LAST = FW'(FRAMES - 1);

  anim_state_e   r_state;
  logic [DW-1:0] r_div;
  logic          w_step;

  assign w_step = frame_tick && anim_run;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_div     <= '0;
      frame_num <= '0;
      anim_done <= 1'b0;
    end else if (anim_start) begin
      r_state   <= RUN;
      r_div     <= '0;
      frame_num <= '0;
      anim_done <= 1'b0;
    end else begin
      case (r_state)
        RUN, HOLD: begin
          // A tick arriving together with anim_run rising is not lost.
          r_state <= anim_run ? RUN : HOLD;
          if (w_step) begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (frame_num != FRM_LAST) begin
                frame_num <= frame_num + 1'b1;
              end else if (ANIM_LOOP != 0) begin
                frame_num <= '0;
              end else begin
                r_state   <= DONE;
                anim_done <= 1'b1;
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Places one animated, scaled and optionally mirrored sprite on the raster;
// drives the sprite ROM and returns a palette index with an opaque flag.
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W     = 60,
  parameter int SPR_H     = 26,
  parameter int FRAMES    = 4,
  parameter int IDX_W     = 3,
  parameter int SCALE_SH  = 0,
  parameter int TRANSP    = 0,
  parameter int ANIM_DIV  = 8,
  parameter int ANIM_LOOP = 1,
  parameter int ADDR_W    = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  coord_t                        DrawX,
  input  coord_t                        DrawY,
  input  logic                          blank,
  input  logic                          frame_tick,
  input  coord_t                        pos_x,
  input  coord_t                        pos_y,
  input  logic                          enable,
  input  logic                          flip_h,
  input  logic                          anim_run,
  input  logic                          anim_start,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [IDX_W-1:0]              rom_q,
  output logic                          pix_valid,
  output logic [IDX_W-1:0]              pix_idx,
  output logic [width_of(FRAMES)-1:0]   frame_num,
  output logic                          anim_done
);

  localparam int          FRAME_SZ = SPR_W * SPR_H;
  localparam logic [10:0] FOOT_W   = 11'(SPR_W << SCALE_SH);
  localparam logic [10:0] FOOT_H   = 11'(SPR_H << SCALE_SH);
  localparam logic [10:0] COL_LAST = 11'(SPR_W - 1);

  coord_t            r_px, r_py;
  logic              r_en, r_flip;
  logic              r_hit_d1, r_hit_d2;
  logic [10:0]       w_dx, w_dy, w_col_raw, w_col, w_row;
  logic              w_hit, w_opaque;
  logic [ADDR_W-1:0] w_addr;

  sprite_anim_ctrl #(
    .FRAMES    (FRAMES),
    .ANIM_DIV  (ANIM_DIV),
    .ANIM_LOOP (ANIM_LOOP)
  ) u_ctrl (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .anim_run   (anim_run),
    .anim_start (anim_start),
    .frame_num  (frame_num),
    .anim_done  (anim_done)
  );

  // Placement only moves during vertical blanking, so a frame never tears.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_px   <= '0;
      r_py   <= '0;
      r_en   <= 1'b0;
      r_flip <= 1'b0;
    end else if (frame_tick) begin
      r_px   <= pos_x;
      r_py   <= pos_y;
      r_en   <= enable;
      r_flip <= flip_h;
    end
  end

  assign w_dx = {1'b0, DrawX} - {1'b0, r_px};
  assign w_dy = {1'b0, DrawY} - {1'b0, r_py};

  // The >= tests keep a negative offset from wrapping into a hit.
  assign w_hit = r_en && blank && (DrawX >= r_px) && (DrawY >= r_py) &&
                 (w_dx < FOOT_W) && (w_dy < FOOT_H);

  assign w_col_raw = w_dx >> SCALE_SH;
  assign w_col     = r_flip ? (COL_LAST - w_col_raw) : w_col_raw;
  assign w_row     = w_dy >> SCALE_SH;
  assign w_addr    = ADDR_W'(frame_num) * ADDR_W'(FRAME_SZ) +
                     ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

  assign w_opaque = r_hit_d2 && (rom_q != IDX_W'(TRANSP));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      r_hit_d1  <= 1'b0;
      r_hit_d2  <= 1'b0;
      pix_valid <= 1'b0;
      pix_idx   <= '0;
    end else begin
      if (w_hit) begin
        rom_addr <= w_addr;
      end
      r_hit_d1  <= w_hit;
      r_hit_d2  <= r_hit_d1;
      pix_valid <= w_opaque;
      pix_idx   <= w_opaque ? rom_q : '0;
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: two instances (1x looping, 2x one-shot)
// share stimulus and are compared every cycle against a behavioural model.
module tb_sprite_anim_renderer;
  import sprite_pkg::*;

  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]    DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic          blank = 1'b0, frame_tick = 1'b0, enable = 1'b0, flip_h = 1'b0;
  logic          anim_run = 1'b0, anim_start = 1'b0;
  logic [AW-1:0] rom_addr0, rom_addr1;
  logic [2:0]    rom_q0 = '0, rom_q1 = '0, pix_idx0, pix_idx1;
  logic          pix_valid0, pix_valid1, done0, done1;
  logic [1:0]    frame0, frame1;

  sprite_anim_renderer #(.SCALE_SH(0), .ANIM_DIV(2), .ANIM_LOOP(1)) dut0 (
    .vga_clk(clk), .reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .flip_h(flip_h), .anim_run(anim_run), .anim_start(anim_start),
    .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_valid(pix_valid0),
    .pix_idx(pix_idx0), .frame_num(frame0), .anim_done(done0));

  sprite_anim_renderer #(.SCALE_SH(1), .ANIM_DIV(2), .ANIM_LOOP(0)) dut1 (
    .vga_clk(clk), .reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .flip_h(flip_h), .anim_run(anim_run), .anim_start(anim_start),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_valid(pix_valid1),
    .pix_idx(pix_idx1), .frame_num(frame1), .anim_done(done1));

  // ROM contents: a fixed address pattern that includes transparent texels.
  function automatic int rom_fn(input int a);
    return (a ^ (a >> 3)) & 7;
  endfunction

  always @(posedge clk) begin
    rom_q0 <= 3'(rom_fn(int'(rom_addr0)));
    rom_q1 <= 3'(rom_fn(int'(rom_addr1)));
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: n = effective animation ticks since start/reset.
  int m_px, m_py, m_en, m_fl;
  int m_n[2];
  int p0_v[2], p0_i[2], p1_v[2], p1_i[2], e_v[2], e_i[2], e_a[2];
  int sc[2]   = '{0, 1};
  int loop[2] = '{1, 0};

  function automatic int m_frame(input int d);
    int s = m_n[d] / 2;
    if (loop[d] != 0) return s % 4;
    return (s > 3) ? 3 : s;
  endfunction

  function automatic int m_done(input int d);
    return (loop[d] == 0 && m_n[d] >= 8) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_en = 0; m_fl = 0;
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; p0_v[d] = 0; p0_i[d] = 0; p1_v[d] = 0; p1_i[d] = 0;
      e_v[d] = 0; e_i[d] = 0; e_a[d] = 0;
    end
  endtask

  task automatic model_pix(input int d, input int x, input int y, input int bl,
                           output int v, output int idx, output int hit, output int addr);
    int col, row, q;
    hit = (m_en != 0 && bl != 0 && x >= m_px && y >= m_py &&
           (x - m_px) < (60 << sc[d]) && (y - m_py) < (26 << sc[d])) ? 1 : 0;
    col = (x - m_px) >>> sc[d];
    if (m_fl != 0) col = 59 - col;
    row = (y - m_py) >>> sc[d];
    addr = m_frame(d) * 1560 + row * 60 + col;
    q = rom_fn(addr);
    v = (hit != 0 && q != 0) ? 1 : 0;
    idx = (v != 0) ? q : 0;
  endtask

  task automatic model_edge();
    int v, idx, hit, addr;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      model_pix(d, int'(DrawX), int'(DrawY), int'(blank), v, idx, hit, addr);
      e_v[d] = p1_v[d]; e_i[d] = p1_i[d];
      p1_v[d] = p0_v[d]; p1_i[d] = p0_i[d];
      p0_v[d] = v; p0_i[d] = idx;
      if (hit != 0) e_a[d] = addr;
    end
    if (frame_tick) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_en = int'(enable); m_fl = int'(flip_h);
    end
    for (int d = 0; d < 2; d++) begin
      if (anim_start) m_n[d] = 0;
      else if (frame_tick && anim_run && m_n[d] < 1000) m_n[d]++;
    end
  endtask

  task automatic check_all();
    chk("pix_valid0", int'(pix_valid0), e_v[0]);
    chk("pix_idx0",   int'(pix_idx0),   e_i[0]);
    chk("rom_addr0",  int'(rom_addr0),  e_a[0]);
    chk("frame0",     int'(frame0),     m_frame(0));
    chk("done0",      int'(done0),      m_done(0));
    chk("pix_valid1", int'(pix_valid1), e_v[1]);
    chk("pix_idx1",   int'(pix_idx1),   e_i[1]);
    chk("rom_addr1",  int'(rom_addr1),  e_a[1]);
    chk("frame1",     int'(frame1),     m_frame(1));
    chk("done1",      int'(done1),      m_done(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic place(input int px, input int py, input int en, input int fl);
    pos_x = 10'(px); pos_y = 10'(py); enable = en[0]; flip_h = fl[0];
    do_tick();
  endtask

  typedef struct {
    int px, py, en, fl, bl, x, y;
    int h0, c0, r0, h1, c1, r1;
  } vec_t;

  vec_t tbl[16];
  int   exp_loop[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
  int   exp_one[8]  = '{0, 1, 1, 2, 2, 3, 3, 3};

  initial begin
    tbl[0]  = '{100, 50, 1, 0, 1, 100,  50, 1,  0,  0, 1,  0,  0};
    tbl[1]  = '{100, 50, 1, 0, 1,  99,  50, 0,  0,  0, 0,  0,  0};
    tbl[2]  = '{100, 50, 1, 0, 1, 159,  75, 1, 59, 25, 1, 29, 12};
    tbl[3]  = '{100, 50, 1, 0, 1, 160,  50, 0,  0,  0, 1, 30,  0};
    tbl[4]  = '{100, 50, 1, 0, 1, 100,  76, 0,  0,  0, 1,  0, 13};
    tbl[5]  = '{100, 50, 1, 0, 1, 219, 101, 0,  0,  0, 1, 59, 25};
    tbl[6]  = '{100, 50, 1, 0, 1, 220,  60, 0,  0,  0, 0,  0,  0};
    tbl[7]  = '{100, 50, 1, 0, 1, 130,  49, 0,  0,  0, 0,  0,  0};
    tbl[8]  = '{100, 50, 1, 1, 1, 100,  50, 1, 59,  0, 1, 59,  0};
    tbl[9]  = '{100, 50, 1, 1, 1, 159,  60, 1,  0, 10, 1, 30,  5};
    tbl[10] = '{620, 470, 1, 0, 1, 620, 470, 1,  0,  0, 1,  0,  0};
    tbl[11] = '{620, 470, 1, 0, 1, 639, 479, 1, 19,  9, 1,  9,  4};
    tbl[12] = '{620, 470, 1, 0, 1,   5,   5, 0,  0,  0, 0,  0,  0};
    tbl[13] = '{620, 470, 1, 0, 1,  19,   9, 0,  0,  0, 0,  0,  0};
    tbl[14] = '{100, 50, 1, 0, 0, 110,  55, 0,  0,  0, 0,  0,  0};
    tbl[15] = '{100, 50, 0, 0, 1, 110,  55, 0,  0,  0, 0,  0,  0};

    model_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Static placement vectors, frame 0 (animation idle).
    foreach (tbl[k]) begin
      int q0, q1, ev0, ev1;
      place(tbl[k].px, tbl[k].py, tbl[k].en, tbl[k].fl);
      DrawX = 10'(tbl[k].x); DrawY = 10'(tbl[k].y); blank = tbl[k].bl[0];
      step();
      DrawX = '0; DrawY = '0; blank = 1'b1;
      step();
      step();
      q0 = rom_fn(tbl[k].r0 * 60 + tbl[k].c0);
      q1 = rom_fn(tbl[k].r1 * 60 + tbl[k].c1);
      ev0 = (tbl[k].h0 != 0 && q0 != 0) ? 1 : 0;
      ev1 = (tbl[k].h1 != 0 && q1 != 0) ? 1 : 0;
      chk($sformatf("tbl%0d_valid0", k), int'(pix_valid0), ev0);
      chk($sformatf("tbl%0d_idx0", k),   int'(pix_idx0),   ev0 != 0 ? q0 : 0);
      chk($sformatf("tbl%0d_valid1", k), int'(pix_valid1), ev1);
      chk($sformatf("tbl%0d_idx1", k),   int'(pix_idx1),   ev1 != 0 ? q1 : 0);
    end

    // Animation: loop vs one-shot, freeze, restart with simultaneous tick.
    anim_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      chk($sformatf("anim_loop_t%0d", i), int'(frame0), exp_loop[i]);
      chk($sformatf("anim_one_t%0d", i),  int'(frame1), exp_one[i]);
    end
    chk("oneshot_done", int'(done1), 1);
    repeat (3) do_tick();
    chk("oneshot_hold_frame", int'(frame1), 3);
    chk("oneshot_hold_done",  int'(done1), 1);
    chk("loop_frame_11", int'(frame0), 1);
    anim_run = 1'b0;
    repeat (4) do_tick();
    chk("freeze_frame0", int'(frame0), 1);
    anim_run = 1'b1;
    anim_start = 1'b1;
    frame_tick = 1'b1;
    step();
    anim_start = 1'b0;
    frame_tick = 1'b0;
    step();
    chk("start_frame0", int'(frame0), 0);
    chk("start_frame1", int'(frame1), 0);
    chk("start_done1",  int'(done1), 0);
    do_tick();
    chk("start_div_t1", int'(frame0), 0);
    do_tick();
    chk("start_div_t2", int'(frame0), 1);

    // Latched position ignores mid-frame pos change; async reset clears output.
    anim_run = 1'b0;
    anim_start = 1'b1;
    step();
    anim_start = 1'b0;
    place(200, 100, 1, 0);
    pos_x = 10'd400;
    DrawX = 10'd205; DrawY = 10'd103; blank = 1'b1;
    repeat (3) step();
    chk("latched_valid0", int'(pix_valid0), 1);
    chk("latched_idx0",   int'(pix_idx0),   6);
    chk("latched_valid1", int'(pix_valid1), 1);
    chk("latched_idx1",   int'(pix_idx1),   1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid0", int'(pix_valid0), 0);
    chk("async_rst_idx0",   int'(pix_idx0),   0);
    chk("async_rst_valid1", int'(pix_valid1), 0);
    model_reset();
    step();
    rst = 1'b0;
    place(200, 100, 1, 0);
    DrawX = 10'd205; DrawY = 10'd103;
    repeat (3) step();
    chk("refill_valid0", int'(pix_valid0), 1);

    // Randomised traffic around the current sprite footprint.
    for (int c = 0; c < 4000; c++) begin
      int tx, ty;
      frame_tick = ($urandom_range(0, 15) == 0);
      anim_start = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) anim_run = ~anim_run;
      if ($urandom_range(0, 7) == 0) begin
        pos_x  = 10'($urandom_range(0, H_ACT - 1));
        pos_y  = 10'($urandom_range(0, V_ACT - 1));
        enable = ($urandom_range(0, 7) != 0);
        flip_h = 1'($urandom_range(0, 1));
      end
      tx = m_px + int'($urandom_range(0, 139)) - 10;
      ty = m_py + int'($urandom_range(0, 69)) - 10;
      if (tx < 0) tx = 0;
      if (tx > H_ACT - 1) tx = H_ACT - 1;
      if (ty < 0) ty = 0;
      if (ty > V_ACT - 1) ty = V_ACT - 1;
      DrawX = 10'(tx);
      DrawY = 10'(ty);
      blank = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
